pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Supervises the SDRAM clock PLL: drives the PLL reset, waits for `locked`, requires lock to stay stable before releasing the SDRAM/core reset, and re-sequences the PLL on timeout or loss of lock. It sits between the top-level reset and the SDRAM PLL wrapper, running on the PLL reference clock so it keeps working while the PLL outputs are invalid. Its `core_rst` and `ready` gate the SDRAM controller and everything clocked from `outclk_0`/`outclk_1`.

## Interface
- `PLL_RST_CYCLES`, default 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 28636: refclk cycles to wait for lock per attempt (≈1 ms at 28.63636 MHz; ≥1).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synced-lock cycles required before release (≥1).
- `MAX_RETRIES`, default 7: failed attempts tolerated before entering FAIL (≥0).
- `refclk`  in  1  sole clock; the PLL reference clock.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL `locked`; asynchronous, synchronized internally.
- `retry_req`  in  1  single-cycle pulse; restarts sequencing from FAIL only.
- `pll_rst`  out  1  to PLL `rst`, active-high.
- `core_rst`  out  1  synchronous active-high reset for the SDRAM/core domain.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  high only in FAIL.
- `lost_lock`  out  1  one-cycle pulse on lock loss while in RUN.
- `retry_count`  out  4  failed attempts in the current sequence.
- `loss_count`  out  8  lock losses in RUN since `rst`, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to `lock_s`. All outputs are registered.
- One cycle counter, width `$clog2` of the largest parameter plus 1, cleared on every state change.
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL.
- Reset (`rst`=1): state RESET_PLL, counter 0, `pll_rst`=1, `core_rst`=1, `ready`=0, `fail`=0, `lost_lock`=0, `retry_count`=0, `loss_count`=0, synchronizer flops 0.
- RESET_PLL:
  - `pll_rst`=1, `core_rst`=1.
  - When the counter reaches `PLL_RST_CYCLES`-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0, `core_rst`=1.
  - `lock_s`=1: go to STABILIZE.
  - Else, when the counter reaches `LOCK_TIMEOUT`-1: if `retry_count`==`MAX_RETRIES`, go to FAIL; otherwise increment `retry_count` and go to RESET_PLL.
- STABILIZE:
  - `core_rst`=1.
  - `lock_s`=0: go to WAIT_LOCK with a fresh timeout. `retry_count` is unchanged.
  - When the counter reaches `LOCK_STABLE_CYCLES`-1 with `lock_s`=1: go to RUN and clear `retry_count`.
- RUN:
  - `core_rst`=0, `ready`=1.
  - `lock_s`=0: pulse `lost_lock`, increment `loss_count` (saturating), go to RESET_PLL.
- FAIL:
  - `pll_rst`=0, `core_rst`=1, `fail`=1.
  - `retry_req`=1: clear `retry_count`, go to RESET_PLL.
  - `retry_req` is ignored in every other state.
- Output encodings:
  - `pll_rst`=1 exactly in RESET_PLL.
  - `core_rst`=0 exactly in RUN.
- `retry_count` saturates at 15. `MAX_RETRIES` must be ≤15.

## Timing
- Synchronizer latency: a `pll_locked` edge is visible on `lock_s` 2 cycles later.
- After `rst` deasserts, `pll_rst` stays high for exactly `PLL_RST_CYCLES` cycles.
- Lock-to-release latency: from the `pll_locked` rise to `core_rst` falling is 2 + `LOCK_STABLE_CYCLES` + 1 cycles, with the lock held throughout.
- Loss of lock in RUN:
  - `core_rst`=1, `ready`=0, `lost_lock`=1 and `pll_rst`=1 all update on the same edge, 3 cycles after `pll_locked` falls.
  - `lost_lock` clears on the following edge.
- A `rst` asserted mid-sequence takes priority over every transition and takes effect on the next edge.
- Simultaneous timeout and `lock_s` rise in WAIT_LOCK: the lock wins, so the state goes to STABILIZE.
- With `LOCK_STABLE_CYCLES`=1, STABILIZE lasts one cycle.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Clean bring-up: release `rst`, raise `pll_locked` 10 cycles later -> `pll_rst` is high for 4 cycles, `core_rst` falls 11 cycles after the lock rise, `ready`=1, `retry_count`=0.
- Timeout then recovery: keep `pll_locked` low for 2 full attempts, then raise it -> two RESET_PLL pulses of 4 cycles each, `retry_count` reaches 2, then RUN is reached and `retry_count` returns to 0.
- Exhaustion: keep `pll_locked` low -> after 3 timeouts `fail`=1, `pll_rst`=0 and `core_rst`=1 stay stable, and `retry_req` resumes sequencing at RESET_PLL.
- Glitch during STABILIZE: drop `pll_locked` for 1 cycle at stable count 5 -> the FSM returns to WAIT_LOCK, `core_rst` stays high, `retry_count` is unchanged, and the release happens 8 stable cycles after re-lock.
- Loss in RUN: drop `pll_locked` -> after 3 cycles `lost_lock` pulses for exactly 1 cycle, `loss_count`=1, `core_rst`=1, `pll_rst`=1 for 4 cycles.
- Reset mid-STABILIZE: assert `rst` for 1 cycle -> all outputs return to their reset values on the next edge, and `loss_count`=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Supervises the SDRAM clock PLL from the PLL reference clock. It holds the
//   PLL in reset, waits for lock, and requires lock to stay stable before it
//   releases the core reset. A timeout or a loss of lock restarts the sequence,
//   and after too many failed attempts the block parks in FAIL until retry_req.
//
// Ports
//   refclk       sole clock (PLL reference clock)
//   rst          synchronous active-high reset
//   pll_locked   PLL locked, asynchronous (2-flop synchronized to lock_s)
//   retry_req    single-cycle pulse, honoured only in FAIL
//   pll_rst      PLL reset, high exactly in RESET_PLL
//   core_rst     SDRAM/core reset, low exactly in RUN
//   ready        high in RUN
//   fail         high in FAIL
//   lost_lock    one-cycle pulse when lock drops while in RUN
//   retry_count  failed attempts in the current sequence (saturates at 15)
//   loss_count   lock losses in RUN since rst (saturates at 255)
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 28636,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic       lost_lock,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_RETRY_C = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             lock_meta, lock_s;
  logic [3:0]       retry_d;
  logic [7:0]       loss_d;
  logic             lost_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    retry_d = retry_count;
    loss_d  = loss_count;
    lost_d  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s) begin
          state_d = S_STABILIZE;
        end else if (cnt == TMO_LAST) begin
          if (retry_count == MAX_RETRY_C) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RESET_PLL;
            retry_d = (retry_count == 4'hf) ? retry_count : retry_count + 4'd1;
          end
        end
      end
      S_STABILIZE: begin
        // A glitch goes back to waiting without counting as a failed attempt.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = 4'd0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RESET_PLL;
          lost_d  = 1'b1;
          loss_d  = (loss_count == 8'hff) ? loss_count : loss_count + 8'd1;
        end
      end
      S_FAIL: begin
        if (retry_req) begin
          state_d = S_RESET_PLL;
          retry_d = 4'd0;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase
    // The counter only times RESET_PLL/WAIT_LOCK/STABILIZE; it is parked at
    // zero elsewhere so it never wraps, and restarts on every state change.
    if (state_d != state || state_d == S_RUN || state_d == S_FAIL) cnt_d = '0;
  end

  // Outputs are registered from the next state so they move on the same edge
  // as the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state       <= S_RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lost_lock   <= 1'b0;
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
    end else begin
      lock_meta   <= pll_locked;
      lock_s      <= lock_meta;
      state       <= state_d;
      cnt         <= cnt_d;
      pll_rst     <= (state_d == S_RESET_PLL);
      core_rst    <= (state_d != S_RUN);
      ready       <= (state_d == S_RUN);
      fail        <= (state_d == S_FAIL);
      lost_lock   <= lost_d;
      retry_count <= retry_d;
      loss_count  <= loss_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with
// hand-derived expectations, then randomized lock/retry/reset traffic checked
// against a countdown-based reference model.
module tb_pll_lock_sequencer;

  localparam int PRST = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_rst, core_rst, ready, fail, lost_lock;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int total = 0;
  int bad   = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT(TMO),
    .LOCK_STABLE_CYCLES(STB), .MAX_RETRIES(MAXR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .core_rst(core_rst), .ready(ready), .fail(fail),
    .lost_lock(lost_lock), .retry_count(retry_count), .loss_count(loss_count)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAIL = 4;
  int m_phase = PH_RST;
  int m_left  = PRST;   // cycles remaining in the current timed phase
  int m_retry = 0;
  int m_loss  = 0;
  bit m_s1 = 0, m_s2 = 0, m_lost = 0;

  task automatic model_step(input bit r, input bit lk, input bit rq);
    bit ls;
    if (r) begin
      m_phase = PH_RST; m_left = PRST; m_retry = 0; m_loss = 0;
      m_s1 = 0; m_s2 = 0; m_lost = 0;
      return;
    end
    ls = m_s2; m_s2 = m_s1; m_s1 = lk;
    m_lost = 0;
    case (m_phase)
      PH_RST: begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_WAIT; m_left = TMO; end
      end
      PH_WAIT: begin
        if (ls) begin m_phase = PH_STAB; m_left = STB; end
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retry == MAXR) m_phase = PH_FAIL;
            else begin
              m_retry = (m_retry < 15) ? m_retry + 1 : 15;
              m_phase = PH_RST; m_left = PRST;
            end
          end
        end
      end
      PH_STAB: begin
        if (!ls) begin m_phase = PH_WAIT; m_left = TMO; end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_RUN; m_retry = 0; end
        end
      end
      PH_RUN: begin
        if (!ls) begin
          m_lost = 1;
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          m_phase = PH_RST; m_left = PRST;
        end
      end
      default: begin
        if (rq) begin m_retry = 0; m_phase = PH_RST; m_left = PRST; end
      end
    endcase
  endtask

  // Advance one clock: the model sees the same inputs the DUT sampled, and
  // outputs are read 1 time unit after the edge.
  task automatic tick();
    bit r, l, q;
    r = rst; l = pll_locked; q = retry_req;
    @(posedge refclk);
    model_step(r, l, q);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [16:0] got, exp;
    rst = 1; pll_locked = 0; retry_req = 0;
    repeat (3) tick();
    got = {pll_rst, core_rst, ready, fail, lost_lock, retry_count, loss_count};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_state got=%h want=%h", got, exp); end
  endtask

  task automatic test_bringup();
    int n;
    rst = 0;
    n = 0;
    do begin tick(); n++; end while (pll_rst === 1'b1 && n < 50);
    total++;
    if (n !== PRST) begin bad++; $display("FAIL bringup_pll_rst_width got=%0d want=%0d", n, PRST); end
    repeat (10 - PRST) tick();
    pll_locked = 1;
    n = 0;
    do begin tick(); n++; end while (core_rst === 1'b1 && n < 50);
    total++;
    if (n !== 2 + STB + 1) begin bad++; $display("FAIL bringup_release_latency got=%0d want=%0d", n, 2 + STB + 1); end
    total++;
    if (ready !== 1'b1 || retry_count !== 4'd0) begin
      bad++; $display("FAIL bringup_ready got ready=%b retry=%0d want ready=1 retry=0", ready, retry_count);
    end
  endtask

  task automatic test_loss();
    int w;
    pll_locked = 0;
    repeat (2) begin
      tick();
      total++;
      if (lost_lock !== 1'b0 || ready !== 1'b1) begin
        bad++; $display("FAIL loss_early got lost=%b ready=%b want lost=0 ready=1", lost_lock, ready);
      end
    end
    tick();
    total++;
    if ({lost_lock, core_rst, pll_rst, ready, loss_count} !== {4'b1110, 8'd1}) begin
      bad++;
      $display("FAIL loss_edge got lost=%b core=%b pll=%b ready=%b loss=%0d want 1 1 1 0 1",
               lost_lock, core_rst, pll_rst, ready, loss_count);
    end
    tick();
    total++;
    if (lost_lock !== 1'b0 || pll_rst !== 1'b1) begin
      bad++; $display("FAIL loss_pulse_clear got lost=%b pll=%b want 0 1", lost_lock, pll_rst);
    end
    w = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_rst !== 1'b1) break;
      w++;
    end
    total++;
    if (w !== PRST) begin bad++; $display("FAIL loss_pll_rst_width got=%0d want=%0d", w, PRST); end
  endtask

  task automatic test_reset_mid();
    pll_locked = 1;
    repeat (5) tick();   // now inside STABILIZE
    total++;
    if (core_rst !== 1'b1 || loss_count !== 8'd1 || ready !== 1'b0) begin
      bad++; $display("FAIL mid_pre got core=%b loss=%0d ready=%b want 1 1 0", core_rst, loss_count, ready);
    end
    rst = 1;
    tick();
    total++;
    if ({pll_rst, core_rst, ready, fail, lost_lock, retry_count, loss_count} !== {5'b11000, 4'd0, 8'd0}) begin
      bad++; $display("FAIL mid_reset got pll=%b core=%b ready=%b fail=%b lost=%b retry=%0d loss=%0d",
                      pll_rst, core_rst, ready, fail, lost_lock, retry_count, loss_count);
    end
  endtask

  task automatic test_timeout();
    int pulses, w, n;
    int widths[2];
    bit prev, in_pulse;
    rst = 1; pll_locked = 0; tick(); rst = 0;
    pulses = 0; w = 0; prev = 1; in_pulse = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pll_rst === 1'b1 && !prev) begin in_pulse = 1; w = 1; end
      else if (pll_rst === 1'b1 && in_pulse) w++;
      else if (pll_rst !== 1'b1 && prev && in_pulse) begin
        if (pulses < 2) widths[pulses] = w;
        pulses++; in_pulse = 0;
        if (pulses == 2) break;
      end
      prev = (pll_rst === 1'b1);
    end
    total++;
    if (pulses !== 2 || widths[0] !== PRST || widths[1] !== PRST) begin
      bad++; $display("FAIL timeout_pulses got n=%0d w0=%0d w1=%0d want 2 %0d %0d",
                      pulses, widths[0], widths[1], PRST, PRST);
    end
    total++;
    if (retry_count !== 4'd2) begin bad++; $display("FAIL timeout_retry got=%0d want=2", retry_count); end
    pll_locked = 1;
    n = 0;
    do begin tick(); n++; end while (core_rst === 1'b1 && n < 60);
    total++;
    if (n !== 2 + STB + 1 || ready !== 1'b1 || retry_count !== 4'd0) begin
      bad++; $display("FAIL timeout_recover got lat=%0d ready=%b retry=%0d want %0d 1 0",
                      n, ready, retry_count, 2 + STB + 1);
    end
  endtask

  task automatic test_exhaust();
    int n;
    rst = 1; pll_locked = 0; tick(); rst = 0;
    n = 0;
    do begin tick(); n++; end while (fail !== 1'b1 && n < 300);
    // 4 reset + 20 wait, twice more with 4+20, then the last wait: 72 cycles
    total++;
    if (n !== PRST + TMO + 2 * (PRST + TMO)) begin
      bad++; $display("FAIL exhaust_time got=%0d want=%0d", n, PRST + TMO + 2 * (PRST + TMO));
    end
    total++;
    if (retry_count !== 4'd2) begin bad++; $display("FAIL exhaust_retry got=%0d want=2", retry_count); end
    repeat (10) begin
      tick();
      total++;
      if ({pll_rst, core_rst, fail, ready} !== 4'b0110) begin
        bad++; $display("FAIL exhaust_hold got pll=%b core=%b fail=%b ready=%b want 0 1 1 0",
                        pll_rst, core_rst, fail, ready);
      end
    end
    retry_req = 1; tick(); retry_req = 0;
    total++;
    if (fail !== 1'b0 || pll_rst !== 1'b1 || retry_count !== 4'd0) begin
      bad++; $display("FAIL exhaust_retry_req got fail=%b pll=%b retry=%0d want 0 1 0", fail, pll_rst, retry_count);
    end
  endtask

  task automatic test_glitch();
    int n;
    rst = 1; pll_locked = 1; tick(); rst = 0;
    repeat (8) tick();        // STABILIZE counter is at 3 here
    pll_locked = 0; tick(); pll_locked = 1;
    // lock_s drops at stable count 5, re-locks one cycle later, then 8 stable cycles
    n = 0;
    do begin tick(); n++; end while (core_rst === 1'b1 && n < 60);
    total++;
    if (n !== 11) begin bad++; $display("FAIL glitch_release got=%0d want=11", n); end
    total++;
    if (retry_count !== 4'd0 || ready !== 1'b1) begin
      bad++; $display("FAIL glitch_retry got retry=%0d ready=%b want 0 1", retry_count, ready);
    end
  endtask

  task automatic test_random();
    int hold, shown;
    logic [16:0] got, exp;
    rst = 1; pll_locked = 0; retry_req = 0; tick(); rst = 0;
    hold = 0; shown = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 40);
      end
      hold--;
      retry_req = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      got = {pll_rst, core_rst, ready, fail, lost_lock, retry_count, loss_count};
      exp = {m_phase == PH_RST, m_phase != PH_RUN, m_phase == PH_RUN, m_phase == PH_FAIL,
             m_lost, 4'(m_retry), 8'(m_loss)};
      total++;
      if (got !== exp) begin
        bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cyc=%0d got=%h want=%h", i, got, exp);
        end
      end
    end
    rst = 0; retry_req = 0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_loss();
    test_reset_mid();
    test_timeout();
    test_exhaust();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
